// File: rtl/fetch_queue_pkg.sv
// Shared sizing and per-instruction info-bit layout for the fetch queue.
package fetch_queue_pkg;
  localparam int DEPTH   = 8;
  localparam int DEPTH_W = 3;
  localparam int INFO_W  = 10;
  localparam int LANES   = 4;
  localparam int SLOTS   = 2;

  // Bit positions inside an info word, LSB first.
  localparam int FQ_INFO_FAULT_FETCH = 0;
  localparam int FQ_INFO_FAULT_PAGE  = 1;
  localparam int FQ_INFO_EXEC        = 2;
  localparam int FQ_INFO_LSU         = 3;
  localparam int FQ_INFO_BRANCH      = 4;
  localparam int FQ_INFO_MUL         = 5;
  localparam int FQ_INFO_DIV         = 6;
  localparam int FQ_INFO_CSR         = 7;
  localparam int FQ_INFO_RD_VALID    = 8;
  localparam int FQ_INFO_INVALID     = 9;
endpackage

// File: rtl/fetch_queue_compact.sv
// Maps accepted frontend lanes to dense write offsets (prefix popcount) and a total count.
module fetch_queue_compact
  import fetch_queue_pkg::*;
(
  input  logic [3:0] i_valid,
  input  logic [3:0] i_accept,
  output logic [3:0] o_we,
  output logic [7:0] o_off,
  output logic [2:0] o_n
);
  logic [2:0] w_run;

  always_comb begin
    w_run = 3'd0;
    o_off = 8'd0;
    o_we  = i_valid & i_accept;
    for (int k = 0; k < LANES; k++) begin
      o_off[2*k +: 2] = w_run[1:0];
      if (o_we[k]) w_run = w_run + 3'd1;
    end
    o_n = w_run;
  end
endmodule

// File: rtl/fetch_queue.sv
// In-order instruction buffer: up to 4 enqueues per cycle, 2 oldest entries presented to issue.
module fetch_queue
  import fetch_queue_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic [3:0]               in_valid_i,
  input  logic [127:0]             in_instr_i,
  input  logic [127:0]             in_pc_i,
  input  logic [4*INFO_W-1:0]      in_info_i,
  output logic [3:0]               in_accept_o,
  output logic [1:0]               out_valid_o,
  output logic [63:0]              out_instr_o,
  output logic [63:0]              out_pc_o,
  output logic [2*INFO_W-1:0]      out_info_o,
  input  logic [1:0]               out_accept_i,
  output logic [DEPTH_W:0]         level_o
);
  // Handshake: an input lane transfers when in_valid_i[k] & in_accept_o[k]; an issue slot
  // transfers when out_valid_o[j] & out_accept_i[j], and slot 1 only together with slot 0.
  logic [31:0]        r_instr [DEPTH];
  logic [31:0]        r_pc    [DEPTH];
  logic [INFO_W-1:0]  r_info  [DEPTH];
  logic [DEPTH_W-1:0] r_rd_ptr;
  logic [DEPTH_W-1:0] r_wr_ptr;
  logic [DEPTH_W:0]   r_count;

  logic [DEPTH_W:0]   w_space;
  logic [3:0]         w_we;
  logic [7:0]         w_off;
  logic [2:0]         w_n;
  logic               w_acc0;
  logic               w_acc1;
  logic [1:0]         w_pop;
  logic [DEPTH_W-1:0] w_rd1;

  // Space comes from the registered count only, so accept never depends on any valid.
  always_comb begin
    w_space = (DEPTH_W+1)'(DEPTH) - r_count;
    for (int k = 0; k < LANES; k++)
      in_accept_o[k] = !flush_i && (w_space >= (DEPTH_W+1)'(k + 1));
  end

  fetch_queue_compact u_compact (
    .i_valid  (in_valid_i),
    .i_accept (in_accept_o),
    .o_we     (w_we),
    .o_off    (w_off),
    .o_n      (w_n)
  );

  assign out_valid_o[0] = (r_count >= (DEPTH_W+1)'(1));
  assign out_valid_o[1] = (r_count >= (DEPTH_W+1)'(2));
  assign w_acc0 = out_accept_i[0] & out_valid_o[0];
  assign w_acc1 = out_accept_i[1] & out_valid_o[1];
  assign w_pop  = {1'b0, w_acc0} + {1'b0, w_acc0 & w_acc1};
  assign w_rd1  = r_rd_ptr + DEPTH_W'(1);

  always_comb begin
    out_instr_o = 64'd0;
    out_pc_o    = 64'd0;
    out_info_o  = '0;
    if (out_valid_o[0]) begin
      out_instr_o[31:0]      = r_instr[r_rd_ptr];
      out_pc_o[31:0]         = r_pc[r_rd_ptr];
      out_info_o[INFO_W-1:0] = r_info[r_rd_ptr];
    end
    if (out_valid_o[1]) begin
      out_instr_o[63:32]            = r_instr[w_rd1];
      out_pc_o[63:32]               = r_pc[w_rd1];
      out_info_o[2*INFO_W-1:INFO_W] = r_info[w_rd1];
    end
  end

  // Storage is not reset; a flush only moves the pointers, so stale writes are harmless.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < LANES; k++) begin
      if (w_we[k]) begin
        r_instr[r_wr_ptr + DEPTH_W'(w_off[2*k +: 2])] <= in_instr_i[32*k +: 32];
        r_pc[r_wr_ptr + DEPTH_W'(w_off[2*k +: 2])]    <= in_pc_i[32*k +: 32];
        r_info[r_wr_ptr + DEPTH_W'(w_off[2*k +: 2])]  <= in_info_i[INFO_W*k +: INFO_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + DEPTH_W'(w_n);
      r_rd_ptr <= r_rd_ptr + DEPTH_W'(w_pop);
      r_count  <= r_count + (DEPTH_W+1)'(w_n) - (DEPTH_W+1)'(w_pop);
    end
  end

  assign level_o = r_count;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with hand-computed expectations.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                flush_i;
  logic [3:0]          in_valid_i;
  logic [127:0]        in_instr_i;
  logic [127:0]        in_pc_i;
  logic [4*INFO_W-1:0] in_info_i;
  logic [3:0]          in_accept_o;
  logic [1:0]          out_valid_o;
  logic [63:0]         out_instr_o;
  logic [63:0]         out_pc_o;
  logic [2*INFO_W-1:0] out_info_o;
  logic [1:0]          out_accept_i;
  logic [DEPTH_W:0]    level_o;

  int n_tests = 0;
  int n_fail  = 0;
  int proto_errs = 0;

  fetch_queue dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_instr_i   (in_instr_i),
    .in_pc_i      (in_pc_i),
    .in_info_i    (in_info_i),
    .in_accept_o  (in_accept_o),
    .out_valid_o  (out_valid_o),
    .out_instr_o  (out_instr_o),
    .out_pc_o     (out_pc_o),
    .out_info_o   (out_info_o),
    .out_accept_i (out_accept_i),
    .level_o      (level_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // issue-side protocol checker
  always @(posedge clk_i) begin
    if (!rst_i && out_accept_i[1] && !out_accept_i[0]) begin
      $display("[TB] protocol: out_accept_i[1] without [0] at %0t", $time);
      proto_errs <= proto_errs + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drive lanes: PC base+4k, instr = 0xA0000000|pc, info = low 10 bits of pc>>2.
  task automatic drive(input logic [3:0] v, input logic [31:0] base);
    in_valid_i = v;
    for (int k = 0; k < 4; k++) begin
      in_pc_i[32*k +: 32]          = base + 32'(4*k);
      in_instr_i[32*k +: 32]       = 32'hA000_0000 | (base + 32'(4*k));
      in_info_i[INFO_W*k +: INFO_W] = INFO_W'((base + 32'(4*k)) >> 2);
    end
  endtask

  task automatic idle();
    in_valid_i   = 4'b0;
    out_accept_i = 2'b00;
    flush_i      = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    drive(4'b0, 32'h0);
    tick(); tick();
    rst_i = 1'b0;
    check("rst_level", 64'(level_o), 64'd0);
    check("rst_valid", 64'(out_valid_o), 64'd0);
    check("rst_accept", 64'(in_accept_o), 64'hF);
    check("rst_pc", out_pc_o, 64'd0);

    // 1: four lanes into empty queue
    drive(4'hF, 32'h1000);
    #1 check("t1_accept", 64'(in_accept_o), 64'hF);
    check("t1_valid_before", 64'(out_valid_o), 64'd0);
    tick(); idle();
    check("t1_valid", 64'(out_valid_o), 64'h3);
    check("t1_pc", out_pc_o, 64'h0000_1004_0000_1000);
    check("t1_instr", out_instr_o, 64'hA000_1004_A000_1000);
    check("t1_info", 64'(out_info_o), 64'({10'h401, 10'h400}));
    check("t1_level", 64'(level_o), 64'd4);

    // 2: fill to 6, then 4 more offered with only 2 slots free
    drive(4'b0011, 32'h1010);
    tick(); idle();
    check("t2_level6", 64'(level_o), 64'd6);
    drive(4'hF, 32'h1018);
    #1 check("t2_accept", 64'(in_accept_o), 64'h3);
    tick();
    check("t2_level8", 64'(level_o), 64'd8);
    check("t2_full_accept", 64'(in_accept_o), 64'h0);
    tick(); idle();
    check("t2_level_held", 64'(level_o), 64'd8);
    out_accept_i = 2'b11;
    check("t2_pop0", out_pc_o, 64'h0000_1004_0000_1000);
    tick();
    check("t2_pop1", out_pc_o, 64'h0000_100C_0000_1008);
    tick();
    check("t2_pop2", out_pc_o, 64'h0000_1014_0000_1010);
    tick();
    check("t2_pop3", out_pc_o, 64'h0000_101C_0000_1018);
    tick(); idle();
    check("t2_empty", 64'(level_o), 64'd0);

    // 3: sparse lanes 1 and 3
    drive(4'b1010, 32'h2000);
    tick(); idle();
    check("t3_level", 64'(level_o), 64'd2);
    check("t3_pc", out_pc_o, 64'h0000_200C_0000_2004);
    out_accept_i = 2'b11;
    tick(); idle();
    check("t3_drain", 64'(level_o), 64'd0);

    // 4: steer rd_ptr to 7 with 3 entries, then pop 2 + enqueue 4 across the wrap
    drive(4'hF, 32'h3000);
    tick();
    drive(4'hF, 32'h3010);
    tick(); idle();
    check("t4_full", 64'(level_o), 64'd8);
    out_accept_i = 2'b11;
    tick(); tick();
    out_accept_i = 2'b01;
    tick(); idle();
    check("t4_level3", 64'(level_o), 64'd3);
    check("t4_wrap_read", out_pc_o, 64'h0000_3018_0000_3014);
    drive(4'hF, 32'h4000);
    out_accept_i = 2'b11;
    #1 check("t4_accept", 64'(in_accept_o), 64'hF);
    tick(); idle();
    check("t4_level5", 64'(level_o), 64'd5);
    check("t4_order", out_pc_o, 64'h0000_4000_0000_301C);
    out_accept_i = 2'b11;
    tick(); idle();
    check("t4_next", out_pc_o, 64'h0000_4008_0000_4004);
    check("t4_level3b", 64'(level_o), 64'd3);

    // 5: flush beats a simultaneous enqueue and pop
    flush_i = 1'b1;
    drive(4'hF, 32'h6000);
    out_accept_i = 2'b11;
    #1 check("t5_accept_flush", 64'(in_accept_o), 64'h0);
    tick(); idle();
    check("t5_level", 64'(level_o), 64'd0);
    check("t5_valid", 64'(out_valid_o), 64'd0);
    check("t5_pc_zero", out_pc_o, 64'd0);
    drive(4'b0001, 32'h5000);
    tick();
    drive(4'b0001, 32'h5004);
    tick(); idle();
    check("t5_post", out_pc_o, 64'h0000_5004_0000_5000);

    // 6: accept[1] alone must not pop
    out_accept_i = 2'b10;
    tick(); idle();
    check("t6_level", 64'(level_o), 64'd2);
    check("t6_pc", out_pc_o, 64'h0000_5004_0000_5000);
    check("t6_proto", 64'(proto_errs), 64'd1);

    // reset mid-operation behaves as a flush
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rst_mid_level", 64'(level_o), 64'd0);
    check("rst_mid_valid", 64'(out_valid_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
